rca_serial_add_ctrl: RTL

- Byte-serial multi-precision adder controller. Sequences one shared 8-bit ripple-carry adder over NBYTES byte slices, least significant byte first.
- A registered carry chains the slices.
- valid/ready handshake on both input and output. Sits between an operand producer (e.g. the ALU issue stage) and a result consumer.

---
 rtl/alu_pkg.sv | 12 +
 rtl/rca_8b_top.sv | 25 ++
 rtl/rca_serial_add_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: controller state encoding and slice width.
package alu_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage : alu_pkg

// File: rtl/rca_8b_top.sv
// 8-bit ripple-carry adder, purely combinational.
module rca_8b_top
    import alu_pkg::*;
(
    output logic [BYTE_W-1:0] sum,
    output logic              carry_out,
    input  logic [BYTE_W-1:0] x,
    input  logic [BYTE_W-1:0] y,
    input  logic              carry_in
);

    // Ripple the carry bit by bit; the chain lives in a block-local variable.
    always_comb begin
        logic [BYTE_W:0] c;
        c    = '0;
        sum  = '0;
        c[0] = carry_in;
        for (int i = 0; i < BYTE_W; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        carry_out = c[BYTE_W];
    end

endmodule : rca_8b_top

// File: rtl/rca_serial_add_ctrl.sv
// Byte-serial multi-precision adder controller. One shared 8-bit adder is
// stepped over NBYTES slices, LSB first, with a registered carry between
// slices.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE (and out of reset); out_valid is
// high only in HOLD, where sum/carry_out/ovf are stable until out_ready.
module rca_serial_add_ctrl
    import alu_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int IDXW   = $clog2(NBYTES),
    localparam int W      = BYTE_W * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         carry_in,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         carry_out,
    output logic         ovf
);

    state_t              state_q;
    state_t              state_d;
    logic [IDXW-1:0]     idx_q;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic                carry_q;
    logic [W-1:0]        sum_q;
    logic                cout_q;
    logic                ovf_q;

    logic [BYTE_W-1:0]   a_byte;
    logic [BYTE_W-1:0]   b_byte;
    logic [BYTE_W-1:0]   add_sum;
    logic                add_cout;
    logic                last_byte;
    logic                accept;

    assign a_byte    = a_q[idx_q * BYTE_W +: BYTE_W];
    assign b_byte    = b_q[idx_q * BYTE_W +: BYTE_W];
    assign last_byte = (idx_q == IDXW'(NBYTES - 1));
    assign accept    = in_valid && in_ready;

    rca_8b_top u_rca (
        .sum       (add_sum),
        .carry_out (add_cout),
        .x         (a_byte),
        .y         (b_byte),
        .carry_in  (carry_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; abort only matters while slices are being added.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ADD;
            ADD: begin
                if (abort)          state_d = IDLE;
                else if (last_byte) state_d = HOLD;
            end
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; in_ready stays low while reset is held.
    always_comb begin
        in_ready  = rst_n && (state_q == IDLE);
        out_valid = (state_q == HOLD);
    end

    // Operand capture, slice accumulation, index and carry chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= carry_in;
                        idx_q   <= '0;
                    end
                end
                ADD: begin
                    if (abort) begin
                        carry_q <= 1'b0;
                        idx_q   <= '0;
                    end else begin
                        sum_q[idx_q * BYTE_W +: BYTE_W] <= add_sum;
                        carry_q <= add_cout;
                        if (last_byte) begin
                            idx_q  <= '0;
                            cout_q <= add_cout;
                            ovf_q  <= (a_q[W-1] == b_q[W-1]) &&
                                      (add_sum[BYTE_W-1] != a_q[W-1]);
                        end else begin
                            idx_q <= idx_q + IDXW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign ovf       = ovf_q;

endmodule : rca_serial_add_ctrl
